// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
// The even-parity helper is used only when PISO_TX_PARITY_EN is defined.
package piso_tx_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Wide enough for any supported word; callers zero-extend, which leaves the XOR unchanged.
    localparam int PARITY_WORD_W = 64;

    function automatic logic parity_f(input logic [PARITY_WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and strobes
// on the final cycle of each bit period.
module piso_bit_timer #(
    parameter int bit_cycles_p = 1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear_i,
    input  logic run_i,
    output logic strobe_o
);

    localparam int CW = (bit_cycles_p > 1) ? $clog2(bit_cycles_p) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(bit_cycles_p - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST_COUNT);
    assign strobe_o  = run_i & w_at_last;

    // Period counter: wraps to zero on each strobe so back-to-back bits stay evenly spaced.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count <= CW'(0);
        end else if (clear_i) begin
            r_count <= CW'(0);
        end else if (strobe_o) begin
            r_count <= CW'(0);
        end else if (run_i) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: sends each accepted word MSB-first with a
// per-bit enable strobe. Define PISO_TX_PARITY_EN to append an even-parity bit.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int width_p      = 5,
    parameter int bit_cycles_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               d_o,
    output logic               enable_o,
    output logic               last_o,
    output logic               busy_o
);

`ifdef PISO_TX_PARITY_EN
    localparam int NB = width_p + 1;
`else
    localparam int NB = width_p;
`endif
    localparam int BLW = $clog2(width_p + 2);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [NB-1:0]     r_shift;
    logic [NB-1:0]     w_capture;
    logic [BLW-1:0]    r_bits_left;
    logic              w_busy;
    logic              w_idle;
    logic              w_strobe;
    logic              w_last;
    logic              w_ready;
    logic              w_load;

    assign w_busy = (r_state == SHIFT);
    assign w_idle = ~w_busy;

    piso_bit_timer #(
        .bit_cycles_p (bit_cycles_p)
    ) u_bit_timer (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (w_idle),
        .run_i    (w_busy),
        .strobe_o (w_strobe)
    );

    assign w_last = w_strobe & (r_bits_left == BLW'(1));
    assign w_load = valid_i & w_ready;

`ifdef PISO_TX_PARITY_EN
    // Parity is computed once at capture so mid-word data_i changes cannot affect it.
    assign w_capture = {data_i, parity_f(PARITY_WORD_W'(data_i))};
`else
    assign w_capture = data_i;
`endif

    // Next-state and ready: ready opens in IDLE and on the final strobe, allowing zero-gap streaming.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (valid_i) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_ready = 1'b1;
                    if (valid_i) begin
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_ready     = 1'b0;
                    w_state_nxt = SHIFT;
                end
            end
            default: begin
                w_ready     = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register and remaining-bit counter; a load takes priority over the closing strobe.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_shift     <= NB'(0);
            r_bits_left <= BLW'(0);
        end else if (w_load) begin
            r_shift     <= w_capture;
            r_bits_left <= BLW'(NB);
        end else if (w_strobe) begin
            r_shift     <= {r_shift[NB-2:0], 1'b0};
            r_bits_left <= r_bits_left - BLW'(1);
        end else begin
            r_shift     <= r_shift;
            r_bits_left <= r_bits_left;
        end
    end

    assign ready_o  = w_ready;
    assign d_o      = w_busy & r_shift[NB-1];
    assign enable_o = w_strobe;
    assign last_o   = w_last;
    assign busy_o   = w_busy;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: a timing model derives every output from the
// handshake cycle and the word; directed literal cases pin that model.
module tb_piso_tx;

    localparam int W  = 5;
    localparam int BC = 3;
`ifdef PISO_TX_PARITY_EN
    localparam int N = W + 1;
    localparam logic [N-1:0]   VEC_11001 = 6'b110011;
    localparam logic [N-1:0]   VEC_10110 = 6'b101101;
    localparam logic [N-1:0]   VEC_10100 = 6'b101000;
    localparam logic [N-1:0]   VEC_01111 = 6'b011110;
    localparam logic [2*N-1:0] STREAM_LIT = 12'b101011_010100;
`else
    localparam int N = W;
    localparam logic [N-1:0]   VEC_11001 = 5'b11001;
    localparam logic [N-1:0]   VEC_10110 = 5'b10110;
    localparam logic [N-1:0]   VEC_10100 = 5'b10100;
    localparam logic [N-1:0]   VEC_01111 = 5'b01111;
    localparam logic [2*N-1:0] STREAM_LIT = 10'b10101_01010;
`endif

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         d_o;
    logic         enable_o;
    logic         last_o;
    logic         busy_o;

    int asserts  = 0;
    int failures = 0;

    logic [15:0] rx = 16'h0000;

    piso_tx #(.width_p(W), .bit_cycles_p(BC)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .d_o      (d_o),
        .enable_o (enable_o),
        .last_o   (last_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural shift receiver attached to the serial link.
    always @(posedge clk_i) begin
        if (enable_o) rx <= {rx[14:0], d_o};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] vec_f(input logic [W-1:0] w);
`ifdef PISO_TX_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Timing model: outputs follow from cycles elapsed since the word's handshake.
    int           n = 0;
    bit           m_act = 1'b0;
    logic [W-1:0] m_word;
    int           m_start;
    int           m_off;
    int           m_bi;
    logic         e_d, e_en, e_last, e_ready;
    bit           rx_pend = 1'b0;
    logic [N-1:0] rx_exp;

    always @(negedge clk_i) begin
        if (!reset_ni) begin
            chk("rst_d", 32'(d_o), 32'd0);
            chk("rst_en", 32'(enable_o), 32'd0);
            chk("rst_last", 32'(last_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_ready", 32'(ready_o), 32'd1);
            m_act   = 1'b0;
            rx_pend = 1'b0;
        end else begin
            e_d = 1'b0; e_en = 1'b0; e_last = 1'b0;
            if (m_act) begin
                m_off  = n - m_start;
                m_bi   = m_off / BC;
                e_en   = ((m_off % BC) == BC - 1);
                e_d    = vec_f(m_word)[N-1-m_bi];
                e_last = e_en && (m_bi == N - 1);
            end
            e_ready = !m_act || e_last;
            chk("m_d", 32'(d_o), 32'(e_d));
            chk("m_en", 32'(enable_o), 32'(e_en));
            chk("m_last", 32'(last_o), 32'(e_last));
            chk("m_busy", 32'(busy_o), 32'(m_act));
            chk("m_ready", 32'(ready_o), 32'(e_ready));
            if (rx_pend) begin
                chk("m_rx", 32'(rx[N-1:0]), 32'(rx_exp));
                rx_pend = 1'b0;
            end
            if (e_last) begin
                rx_pend = 1'b1;
                rx_exp  = vec_f(m_word);
                m_act   = 1'b0;
            end
            if (valid_i && e_ready) begin
                m_act   = 1'b1;
                m_word  = data_i;
                m_start = n + 1;
            end
        end
        n++;
    end

    task automatic send_word(input logic [W-1:0] w);
        int k;
        valid_i = 1'b1;
        data_i  = w;
        k = 0;
        @(negedge clk_i);
        while (!ready_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 200) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        data_i  = W'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk_i);
        while (busy_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 200) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*N-1:0] sbits;
        int got, cyc, first, lastc, k;
        bit busy_all;

        reset_ni = 1'b0;
        valid_i  = 1'b0;
        data_i   = W'(0);
        repeat (3) @(posedge clk_i);
        #2 reset_ni = 1'b1;
        @(negedge clk_i);
        chk("init_ready", 32'(ready_o), 32'd1);
        chk("init_busy", 32'(busy_o), 32'd0);
        chk("init_en", 32'(enable_o), 32'd0);
        chk("init_d", 32'(d_o), 32'd0);

        // Directed word 11001: bit held BC cycles, strobe on each period's last cycle.
        send_word(5'b11001);
        for (int i = 1; i <= N * BC; i++) begin
            @(negedge clk_i);
            chk("w11001_en", 32'(enable_o), 32'((i % BC) == 0));
            chk("w11001_d", 32'(d_o), 32'(VEC_11001[N-1-(i-1)/BC]));
            chk("w11001_last", 32'(last_o), 32'(i == N * BC));
            chk("w11001_ready", 32'(ready_o), 32'(i == N * BC));
        end
        wait_idle();
        chk("w11001_rx", 32'(rx[N-1:0]), 32'(VEC_11001));

        // Parity-relevant words and receiver contract.
        send_word(5'b10110);
        wait_idle();
        chk("w10110_rx", 32'(rx[N-1:0]), 32'(VEC_10110));
        send_word(5'b10100);
        wait_idle();
        chk("w10100_rx", 32'(rx[N-1:0]), 32'(VEC_10100));

        // Back-to-back streaming with no gap.
        sbits = '0; got = 0; cyc = 0; first = -1; lastc = -1; busy_all = 1'b1;
        fork
            begin
                send_word(5'h15);
                send_word(5'h0A);
            end
            begin
                while (got < 2 * N && cyc < 400) begin
                    @(negedge clk_i);
                    cyc++;
                    if (first >= 0) busy_all = busy_all & busy_o;
                    if (enable_o) begin
                        sbits = {sbits[2*N-2:0], d_o};
                        if (first < 0) first = cyc;
                        lastc = cyc;
                        got++;
                    end
                end
            end
        join
        chk("stream_bits", 32'(sbits), 32'(STREAM_LIT));
        chk("stream_span", 32'(lastc - first), 32'((2 * N - 1) * BC));
        chk("stream_busy", 32'(busy_all), 32'd1);
        wait_idle();

        // Input noise while ready is low must not disturb the word in flight.
        send_word(5'b10011);
        for (int j = 1; j <= N * BC - 2; j++) begin
            @(posedge clk_i);
            #1;
            valid_i = 1'($urandom);
            data_i  = W'($urandom);
        end
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        wait_idle();
        chk("noise_rx", 32'(rx[N-1:0]), 32'(vec_f(5'b10011)));

        // Asynchronous reset mid-word, then a clean word.
        send_word(5'b10110);
        k = 0;
        while (k < 2) begin
            @(negedge clk_i);
            if (enable_o) k++;
        end
        @(posedge clk_i);
        #2 reset_ni = 1'b0;
        #1;
        chk("arst_d", 32'(d_o), 32'd0);
        chk("arst_en", 32'(enable_o), 32'd0);
        chk("arst_last", 32'(last_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #2 reset_ni = 1'b1;
        send_word(5'b01111);
        wait_idle();
        chk("post_rst_rx", 32'(rx[N-1:0]), 32'(VEC_01111));

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk_i);
            #1;
            valid_i = ($urandom % 3) != 0;
            data_i  = W'($urandom);
        end
        valid_i = 1'b0;
        repeat (N * BC + 4) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
